// File: rtl/ctrl_pkg.sv
// Shared types for the pipelined control unit: opcodes, ALU op codes, control bundle.
package ctrl_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluAnd   = 4'd2,
    AluOr    = 4'd3,
    AluXor   = 4'd4,
    AluSll   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluSlt   = 4'd8,
    AluSltu  = 4'd9,
    AluPassB = 4'd10,
    AluAddPc = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    ImmI = 3'b000,
    ImmS = 3'b001,
    ImmB = 3'b010,
    ImmU = 3'b011,
    ImmJ = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    ResAlu = 2'b00,
    ResMem = 2'b01,
    ResPc4 = 2'b10
  } res_src_e;

  typedef enum logic {
    StIdle,
    StBusy
  } mop_state_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     alu_src;
    logic     branch;
    logic     jump;
    logic     jalr;
    logic     mul_op;
    logic     illegal;
    imm_src_e imm_src;
    res_src_e res_src;
    alu_op_e  alu_ctrl;
    logic [2:0] funct3;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CtrlNop = '0;

  // alt selects sub/sra (funct7[5]) where the encoding allows it.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational RV32I (+ optional M) decoder: instruction word to control bundle.
module control_decoder
  import ctrl_pkg::*;
#(
  parameter bit EN_MUL = 1'b1
) (
  input  logic [31:0]  instr,
  input  logic         valid,
  output ctrl_bundle_t ctrl,
  output logic         illegal,
  output logic         is_mop
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign f3            = instr[14:12];
  assign f7            = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  ctrl_bundle_t dec;
  logic         legal;
  logic         mop;

  always_comb begin
    dec        = CtrlNop;
    dec.funct3 = f3;
    legal      = 1'b0;
    mop        = 1'b0;
    case (opcode)
      OpReg: begin
        if (f7 == F7Base || (f7 == F7Alt && (f3 == 3'b000 || f3 == 3'b101))) begin
          legal         = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_ctrl  = alu_from_f3(f3, f7[5]);
        end else if (EN_MUL && f7 == F7Mul) begin
          legal         = 1'b1;
          mop           = 1'b1;
          dec.reg_write = 1'b1;
          dec.mul_op    = 1'b1;
        end
      end
      OpImm: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = ImmI;
        dec.alu_ctrl  = alu_from_f3(f3, 1'b0);
        if (f3 == 3'b001) begin
          legal = (f7 == F7Base);
        end else if (f3 == 3'b101) begin
          legal        = (f7 == F7Base) || (f7 == F7Alt);
          dec.alu_ctrl = alu_from_f3(f3, f7[5]);
        end else begin
          legal = 1'b1;
        end
      end
      OpLoad: begin
        legal         = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = ImmI;
        dec.res_src   = ResMem;
      end
      OpStore: begin
        legal         = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = ImmS;
      end
      OpBranch: begin
        legal       = (f3 != 3'b010) && (f3 != 3'b011);
        dec.branch  = 1'b1;
        dec.imm_src = ImmB;
        // eq/ne compare via SUB, lt/ge via SLT, ltu/geu via SLTU
        dec.alu_ctrl = (f3[2:1] == 2'b00) ? AluSub : (f3[1] ? AluSltu : AluSlt);
      end
      OpLui: begin
        legal         = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = ImmU;
        dec.alu_ctrl  = AluPassB;
      end
      OpAuipc: begin
        legal         = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = ImmU;
        dec.alu_ctrl  = AluAddPc;
      end
      OpJal: begin
        legal         = 1'b1;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.imm_src   = ImmJ;
        dec.res_src   = ResPc4;
      end
      OpJalr: begin
        legal         = (f3 == 3'b000);
        dec.reg_write = 1'b1;
        dec.jalr      = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = ImmI;
        dec.res_src   = ResPc4;
      end
      default: legal = 1'b0;
    endcase
  end

  assign ctrl    = legal ? dec : CtrlNop;
  assign illegal = valid & ~legal;
  assign is_mop  = legal & mop;

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: ID decode, multi-cycle M-op stall FSM and ID/EX control register.
module control_unit_pipe
  import ctrl_pkg::*;
#(
  parameter bit          EN_MUL      = 1'b1,
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned ALU_CTRL_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           InstrD,
  input  logic                  ValidD,
  input  logic                  StallE,
  input  logic                  FlushE,
  output logic                  MulStall,
  output logic                  IllegalD,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  ALUSrcE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic                  JalrE,
  output logic                  MulOpE,
  output logic                  IllegalE,
  output logic [2:0]            ImmSrcE,
  output logic [1:0]            ResultSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic [2:0]            Funct3E
);

  localparam int unsigned CntW = $clog2(MUL_LATENCY + 1);

  ctrl_bundle_t    dec, idex_d, idex_q;
  logic            is_mop, mop_req, bubble;
  mop_state_e      state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  control_decoder #(
    .EN_MUL(EN_MUL)
  ) u_dec (
    .instr  (InstrD),
    .valid  (ValidD),
    .ctrl   (dec),
    .illegal(IllegalD),
    .is_mop (is_mop)
  );

  assign mop_req = ValidD & is_mop;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    MulStall = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mop_req && !FlushE) begin
          MulStall = 1'b1;
          cnt_d    = CntW'(MUL_LATENCY - 1);
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (FlushE) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          MulStall = 1'b1;
          cnt_d    = cnt_q - CntW'(1);
        end else if (!StallE) begin
          // Stall released: the M-op issues into ID/EX this edge.
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bubble = FlushE | ~ValidD | IllegalD | MulStall;

  always_comb begin
    idex_d = dec;
    if (bubble) begin
      idex_d         = CtrlNop;
      idex_d.illegal = IllegalD & ~FlushE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idex_q  <= CtrlNop;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!StallE) idex_q <= idex_d;
    end
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign ALUSrcE     = idex_q.alu_src;
  assign BranchE     = idex_q.branch;
  assign JumpE       = idex_q.jump;
  assign JalrE       = idex_q.jalr;
  assign MulOpE      = idex_q.mul_op;
  assign IllegalE    = idex_q.illegal;
  assign ImmSrcE     = idex_q.imm_src;
  assign ResultSrcE  = idex_q.res_src;
  assign ALUControlE = ALU_CTRL_W'(idex_q.alu_ctrl);
  assign Funct3E     = idex_q.funct3;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Scoreboard bench for control_unit_pipe: stimulus queues expected ID/EX bundles, monitor checks.
module tb_control_unit_pipe;

  typedef struct packed {
    logic [7:0] flags;  // rw mw as br j jr mo il
    logic [2:0] imm;
    logic [1:0] res;
    logic [3:0] alu;
    logic [2:0] f3;
  } exp_t;

  localparam logic [31:0] IAdd = 32'h00B50533;
  localparam logic [31:0] ISub = 32'h40B50533;
  localparam logic [31:0] IBlt = 32'h00B54663;
  localparam logic [31:0] ILui = 32'h123402B7;
  localparam logic [31:0] ISw  = 32'h00B52223;
  localparam logic [31:0] IJal = 32'h000000EF;
  localparam logic [31:0] ILw  = 32'h0005A503;
  localparam logic [31:0] IMul = 32'h02B50533;
  localparam logic [31:0] IBad = 32'hFFFFFFFF;

  localparam exp_t ENop = '0;
  localparam exp_t EAdd = {8'b1000_0000, 3'b000, 2'b00, 4'd0, 3'b000};
  localparam exp_t ESub = {8'b1000_0000, 3'b000, 2'b00, 4'd1, 3'b000};
  localparam exp_t EBlt = {8'b0001_0000, 3'b010, 2'b00, 4'd8, 3'b100};
  localparam exp_t ELui = {8'b1010_0000, 3'b011, 2'b00, 4'd10, 3'b000};
  localparam exp_t ESw  = {8'b0110_0000, 3'b001, 2'b00, 4'd0, 3'b010};
  localparam exp_t EJal = {8'b1000_1000, 3'b100, 2'b10, 4'd0, 3'b000};
  localparam exp_t ELw  = {8'b1010_0000, 3'b000, 2'b01, 4'd0, 3'b010};
  localparam exp_t EMul = {8'b1000_0010, 3'b000, 2'b00, 4'd0, 3'b000};
  localparam exp_t EIll = {8'b0000_0001, 3'b000, 2'b00, 4'd0, 3'b000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] InstrD = IAdd;
  logic        ValidD = 1'b1;
  logic        StallE = 1'b0;
  logic        FlushE = 1'b0;

  logic       MulStall, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE;
  logic       MulOpE, IllegalE;
  logic [2:0] ImmSrcE, Funct3E;
  logic [1:0] ResultSrcE;
  logic [3:0] ALUControlE;

  logic       MulStall1, IllegalD1;
  logic [7:0] unused1_flags;
  logic [2:0] unused1_imm, unused1_f3;
  logic [1:0] unused1_res;
  logic [3:0] unused1_alu;

  exp_t act;
  assign act = {RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE, MulOpE, IllegalE,
                ImmSrcE, ResultSrcE, ALUControlE, Funct3E};

  always #5 clk = ~clk;

  control_unit_pipe #(.EN_MUL(1'b1), .MUL_LATENCY(4), .ALU_CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .MulStall(MulStall), .IllegalD(IllegalD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .MulOpE(MulOpE),
    .IllegalE(IllegalE), .ImmSrcE(ImmSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E)
  );

  control_unit_pipe #(.EN_MUL(1'b0), .MUL_LATENCY(4), .ALU_CTRL_W(4)) dut_nomul (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .MulStall(MulStall1), .IllegalD(IllegalD1), .RegWriteE(unused1_flags[7]),
    .MemWriteE(unused1_flags[6]), .ALUSrcE(unused1_flags[5]), .BranchE(unused1_flags[4]),
    .JumpE(unused1_flags[3]), .JalrE(unused1_flags[2]), .MulOpE(unused1_flags[1]),
    .IllegalE(unused1_flags[0]), .ImmSrcE(unused1_imm), .ResultSrcE(unused1_res),
    .ALUControlE(unused1_alu), .Funct3E(unused1_f3)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Drive one ID cycle; exp_ms < 0 skips the MulStall check.
  task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                      input logic r, input exp_t e, input string nm, input int exp_ms);
    @(negedge clk);
    InstrD = ins;
    ValidD = v;
    StallE = st;
    FlushE = fl;
    rst    = r;
    #1;
    if (exp_ms >= 0) check({nm, "_mulstall"}, {31'd0, MulStall}, exp_ms[31:0]);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(posedge clk) begin
    exp_t  e;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, {12'd0, act}, {12'd0, e});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(IAdd, 1, 0, 0, 1, ENop, "rst0", 0);
    step(IAdd, 1, 0, 0, 1, ENop, "rst1", 0);
    step(IAdd, 1, 0, 0, 0, EAdd, "add", 0);
    step(ISub, 1, 0, 0, 0, ESub, "sub", 0);
    step(IBlt, 1, 0, 0, 0, EBlt, "blt", 0);
    step(ILui, 1, 0, 0, 0, ELui, "lui", 0);
    step(ISw,  1, 0, 0, 0, ESw,  "sw", 0);
    step(IJal, 1, 0, 0, 0, EJal, "jal", 0);
    step(IAdd, 0, 0, 0, 0, ENop, "invalid", 0);

    for (int i = 0; i < 4; i++) step(IMul, 1, 0, 0, 0, ENop, "mul_bubble", 1);
    step(IMul, 1, 0, 0, 0, EMul, "mul_issue", 0);
    step(IAdd, 1, 0, 0, 0, EAdd, "after_mul", 0);

    step(IMul, 1, 0, 0, 0, ENop, "abort_idle", 1);
    step(IMul, 1, 0, 0, 0, ENop, "abort_cnt3", 1);
    step(IMul, 1, 0, 1, 0, ENop, "abort_flush", 0);
    step(IAdd, 1, 0, 0, 0, EAdd, "abort_idle_after", 0);

    step(ILw,  1, 0, 0, 0, ELw, "lw", 0);
    for (int i = 0; i < 3; i++) step(IAdd, 1, 1, 0, 0, ELw, "lw_hold", 0);
    step(IAdd, 1, 0, 1, 0, ENop, "flush", 0);

    step(IBad, 1, 0, 0, 0, EIll, "illegal", 0);
    check("illegal_d", {31'd0, IllegalD}, 32'd1);

    step(IMul, 1, 0, 0, 0, ENop, "nomul_start", 1);
    check("nomul_illegal_d", {31'd0, IllegalD1}, 32'd1);
    check("nomul_mulstall", {31'd0, MulStall1}, 32'd0);
    check("mul_legal_d", {31'd0, IllegalD}, 32'd0);
    step(IMul, 1, 0, 0, 0, ENop, "busy_before_rst", 1);
    step(IMul, 1, 0, 0, 1, ENop, "rst_in_busy", -1);
    step(IAdd, 0, 0, 0, 0, ENop, "post_rst_idle", 0);
    step(IAdd, 1, 0, 0, 0, EAdd, "final_add", 0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
